// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter
// Arbitrates two frame requesters onto one byte-wide UART transmitter.
// Each frame is: SOF_BYTE, header {id, 2'b00, L}, L payload bytes, checksum.
// The checksum is the XOR of the header and all payload bytes.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req[1:0]              level frame request per requester
//   len0/len1[4:0]        payload length per requester, sampled at grant
//   data0/data1[7:0]      current payload byte per requester
//   pop[1:0]              one-cycle pulse, payload byte of requester i consumed
//   grant[1:0]            one-hot owner of the transmitter for the whole frame
//   frame_done[1:0]       one-cycle pulse when requester i's frame finishes
//   busy                  high from grant through the frame_done cycle
//   tx_start, tx_data     byte handoff to the UART transmitter
//   tx_active, tx_done    status from the UART transmitter
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; arbitrate once the UART is fully idle
// S_LOAD  | put the next frame byte on tx_data, arm tx_start
// S_START | tx_start high for this single cycle
// S_WAIT  | wait for a rising edge of tx_done
// S_GAP   | wait for the UART to go idle, then next byte or finish
// S_DONE  | frame_done pulse, release grant, rotate priority
module uart_tx_frame_arbiter #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [4:0] len0,
  input  logic [4:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] pop,
  output logic [1:0] grant,
  output logic [1:0] frame_done,
  output logic       busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_active,
  input  logic       tx_done
);

  localparam logic [4:0] MAX_L = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t     state;
  logic       prio;
  logic       id;
  logic [4:0] len_q;
  logic [4:0] byte_idx;
  logic [7:0] csum;
  logic       tx_done_q;

  logic       win_id;
  logic [4:0] win_len;
  logic [4:0] win_len_clamped;
  logic [7:0] header;
  logic [7:0] payload;
  logic       tx_done_rise;
  logic       uart_idle;

  always_comb begin
    win_id = prio;
    if (req == 2'b01) win_id = 1'b0;
    else if (req == 2'b10) win_id = 1'b1;
    win_len         = win_id ? len1 : len0;
    win_len_clamped = (win_len > MAX_L) ? MAX_L : win_len;
  end

  assign header       = {id, 2'b00, len_q};
  assign payload      = id ? data1 : data0;
  // Edge detect so a tx_done level still high from the previous byte,
  // or held for two cycles, advances the frame exactly once.
  assign tx_done_rise = tx_done & ~tx_done_q;
  assign uart_idle    = ~tx_active & ~tx_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      prio       <= 1'b0;
      id         <= 1'b0;
      len_q      <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      tx_done_q  <= 1'b0;
      pop        <= '0;
      grant      <= '0;
      frame_done <= '0;
      busy       <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      tx_done_q  <= tx_done;
      tx_start   <= 1'b0;
      pop        <= '0;
      frame_done <= '0;
      case (state)
        S_IDLE: begin
          if (req != 2'b00 && uart_idle) begin
            id       <= win_id;
            len_q    <= win_len_clamped;
            grant    <= win_id ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            byte_idx <= '0;
            csum     <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_start <= 1'b1;
          byte_idx <= byte_idx + 5'd1;
          state    <= S_START;
          if (byte_idx == 5'd0) begin
            tx_data <= SOF_BYTE;
          end else if (byte_idx == 5'd1) begin
            tx_data <= header;
            csum    <= header;
          end else if (byte_idx == len_q + 5'd2) begin
            tx_data <= csum;
          end else begin
            tx_data <= payload;
            csum    <= csum ^ payload;
            pop     <= id ? 2'b10 : 2'b01;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (tx_done_rise) state <= S_GAP;
        end
        S_GAP: begin
          if (uart_idle) begin
            if (byte_idx == len_q + 5'd3) begin
              frame_done <= grant;
              state      <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          prio  <= ~id;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
module tb_uart_tx_frame_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [4:0] len0, len1;
  logic [7:0] data0, data1;
  logic [1:0] pop, grant, frame_done;
  logic       busy, tx_start;
  logic [7:0] tx_data;
  logic       tx_active, tx_done;

  always #5 clk = ~clk;

  uart_tx_frame_arbiter #(.SOF_BYTE(8'hA5), .MAX_LEN(16)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .pop(pop), .grant(grant),
    .frame_done(frame_done), .busy(busy), .tx_start(tx_start),
    .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: 3 active cycles, then tx_done for done_len cycles.
  localparam int ACT = 3;
  int         done_len = 1;
  int         uart_cnt = 0;
  int         start_viol = 0;
  logic [7:0] cap[$];

  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        if (tx_active || tx_done) start_viol++;
        cap.push_back(tx_data);
        uart_cnt = ACT + done_len;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
      end
      tx_active = (uart_cnt > done_len);
      tx_done   = (uart_cnt > 0) && (uart_cnt <= done_len);
    end
  end

  // Requesters and event counters, sampled on the falling edge.
  logic [7:0] pay0[32];
  logic [7:0] pay1[32];
  int i0 = 0, i1 = 0;
  int pop0_cnt = 0, pop1_cnt = 0, fd0_cnt = 0, fd1_cnt = 0, pop_viol = 0;

  always @(negedge clk) begin
    if ((pop & ~grant) != 2'b00) pop_viol++;
    if (pop[0]) begin
      pop0_cnt++;
      i0++;
      data0 = pay0[i0 & 31];
    end
    if (pop[1]) begin
      pop1_cnt++;
      i1++;
      data1 = pay1[i1 & 31];
    end
    if (frame_done[0]) fd0_cnt++;
    if (frame_done[1]) fd1_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int n = 0;
    while ((fd0_cnt + fd1_cnt) < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'((fd0_cnt + fd1_cnt) >= target), 32'd1);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(cap.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < cap.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), 32'(cap[k]), 32'(exp[k]));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] cs;
  int b_fd, b_p0, b_p1, b_f0, b_f1, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    len0  = '0;
    len1  = '0;
    for (int k = 0; k < 32; k++) begin
      pay0[k] = '0;
      pay1[k] = '0;
    end
    data0 = 8'h00;
    data1 = 8'h00;
    cyc(3);
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    // Requester 0, two payload bytes; req dropped mid-frame.
    pay0[0] = 8'h11; pay0[1] = 8'h22; i0 = 0; data0 = pay0[0];
    len0 = 5'd2;
    cap.delete();
    b_fd = fd0_cnt + fd1_cnt; b_p0 = pop0_cnt; b_p1 = pop1_cnt; b_f0 = fd0_cnt;
    req = 2'b01;
    cyc(1);
    chk("lat_grant", 32'(grant), 32'h1);
    chk("lat_busy", 32'(busy), 32'h1);
    chk("lat_no_start_yet", 32'(tx_start), 32'h0);
    cyc(1);
    chk("lat_tx_start", 32'(tx_start), 32'h1);
    chk("lat_tx_data_sof", 32'(tx_data), 32'hA5);
    req = 2'b00;
    wait_fd(b_fd + 1, 400, "f1_done_in_time");
    cyc(3);
    exp_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
    chk_bytes("f1", exp_q);
    chk("f1_pop0", 32'(pop0_cnt - b_p0), 32'd2);
    chk("f1_pop1", 32'(pop1_cnt - b_p1), 32'd0);
    chk("f1_fd0", 32'(fd0_cnt - b_f0), 32'd1);
    chk("f1_busy_clear", 32'(busy), 32'h0);

    // Requester 1, zero-length payload.
    len1 = 5'd0;
    cap.delete();
    b_fd = fd0_cnt + fd1_cnt; b_p0 = pop0_cnt; b_p1 = pop1_cnt; b_f1 = fd1_cnt;
    req = 2'b10;
    cyc(2);
    req = 2'b00;
    wait_fd(b_fd + 1, 400, "f2_done_in_time");
    cyc(3);
    exp_q = {8'hA5, 8'h80, 8'h80};
    chk_bytes("f2", exp_q);
    chk("f2_pops", 32'((pop0_cnt - b_p0) + (pop1_cnt - b_p1)), 32'd0);
    chk("f2_fd1", 32'(fd1_cnt - b_f1), 32'd1);

    // Length clamp with tx_done held two cycles per byte.
    done_len = 2;
    for (int k = 0; k < 32; k++) pay0[k] = 8'(k * 37 + 5);
    i0 = 0; data0 = pay0[0];
    len0 = 5'd31;
    cap.delete();
    b_fd = fd0_cnt + fd1_cnt; b_p0 = pop0_cnt;
    start_viol = 0;
    req = 2'b01;
    cyc(2);
    req = 2'b00;
    wait_fd(b_fd + 1, 1000, "f3_done_in_time");
    cyc(3);
    exp_q = {8'hA5, 8'h10};
    cs = 8'h10;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(pay0[k]);
      cs = cs ^ pay0[k];
    end
    exp_q.push_back(cs);
    chk_bytes("f3", exp_q);
    chk("f3_pop0", 32'(pop0_cnt - b_p0), 32'd16);
    chk("f3_start_while_busy", 32'(start_viol), 32'd0);
    done_len = 1;

    // Both requesting after reset: 0, then 1, then 0 again.
    pulse_reset();
    pay0[0] = 8'h3C; pay0[1] = 8'h5A; i0 = 0; data0 = pay0[0];
    pay1[0] = 8'h77; pay1[1] = 8'h0F; i1 = 0; data1 = pay1[0];
    len0 = 5'd1; len1 = 5'd2;
    cap.delete();
    b_fd = fd0_cnt + fd1_cnt;
    req = 2'b11;
    wait_fd(b_fd + 3, 1500, "rr_done_in_time");
    req = 2'b00;
    cyc(3);
    exp_q = {8'hA5, 8'h01, 8'h3C, 8'h3D,
             8'hA5, 8'h82, 8'h77, 8'h0F, 8'hFA,
             8'hA5, 8'h01, 8'h5A, 8'h5B};
    chk_bytes("rr", exp_q);
    chk("rr_pop_owner", 32'(pop_viol), 32'd0);

    // Reset during payload byte 3 of a requester-1 frame.
    for (int k = 0; k < 32; k++) pay1[k] = 8'(8'h40 + k);
    i1 = 0; data1 = pay1[0];
    len1 = 5'd5;
    b_p1 = pop1_cnt; b_f1 = fd1_cnt; b_fd = fd0_cnt + fd1_cnt;
    start_viol = 0;
    req = 2'b10;
    n = 0;
    while ((pop1_cnt - b_p1) < 3 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("mr_reached_byte3", 32'((pop1_cnt - b_p1) >= 3), 32'd1);
    cyc(1);
    reset = 1'b1;
    req = 2'b11;
    cap.delete();
    cyc(1);
    reset = 1'b0;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_tx_data", 32'(tx_data), 32'h0);
    chk("mr_tx_start", 32'(tx_start), 32'h0);
    cyc(1);
    chk("mr_hold_while_uart_busy", 32'(grant), 32'h0);
    pay0[0] = 8'hC3; i0 = 0; data0 = pay0[0];
    len0 = 5'd1;
    n = 0;
    while (grant == 2'b00 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("mr_regrant_prio0", 32'(grant), 32'h1);
    req = 2'b00;
    wait_fd(b_fd + 1, 400, "mr_done_in_time");
    cyc(3);
    exp_q = {8'hA5, 8'h01, 8'hC3, 8'hC2};
    chk_bytes("mr", exp_q);
    chk("mr_no_fd1", 32'(fd1_cnt - b_f1), 32'd0);
    chk("mr_start_while_busy", 32'(start_viol), 32'd0);
    chk("all_pop_owner", 32'(pop_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
